sram_arb_ctrl: RTL

//  Two-port arbitrating controller for the 4 x 2Mx8 asynchronous SRAM bank (8 MB) on the board.

---
 rtl/sram_ctrl_pkg.sv | 24 ++
 rtl/sram_rr_arbiter.sv | 35 +++
 rtl/sram_arb_ctrl.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/sram_ctrl_pkg.sv
// rtl/sram_ctrl_pkg.sv - shared types and sizes for the SRAM arbitrating controller
// Purpose: FSM state encoding, bus widths and the chip-select decode helper.
package sram_ctrl_pkg;

    localparam int SRAM_AW    = 21;
    localparam int CHIP_SEL_W = 2;
    localparam int DATA_W     = 8;
    localparam int NUM_CHIPS  = 4;
    localparam int ADDR_W     = SRAM_AW + CHIP_SEL_W;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ACCESS,
        ST_HOLD,
        ST_TURN
    } state_e;

    // One-hot-low chip select for the chip field of a byte address.
    function automatic logic [NUM_CHIPS-1:0] chip_sel_n(input logic [CHIP_SEL_W-1:0] chip);
        return ~(NUM_CHIPS'(1) << chip);
    endfunction

endpackage

// File: rtl/sram_rr_arbiter.sv
// rtl/sram_rr_arbiter.sv - two-way round-robin arbiter with priority pointer
// Purpose: picks one of two requesters; on a tie the port not granted last wins.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   en           arbitration allowed (controller idle)
//   req[1:0]     request levels
//   gnt_valid    a grant is issued this cycle
//   gnt_idx      granted port index
module sram_rr_arbiter (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [1:0] req,
    output logic       gnt_valid,
    output logic       gnt_idx
);

    // ptr_q names the port that wins a tie; reset favours port 0.
    logic ptr_q, ptr_d;

    always_comb begin
        gnt_valid = en & (|req);
        gnt_idx   = (req == 2'b11) ? ptr_q : req[1];
        ptr_d     = gnt_valid ? ~gnt_idx : ptr_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/sram_arb_ctrl.sv
// rtl/sram_arb_ctrl.sv - two-port arbitrating controller for the asynchronous SRAM bank
// Purpose: grants the shared SRAM bus round-robin between CPU (port 0) and DMA (port 1)
// and sequences CS/RD/WR strobes with programmable wait states.
// Ports:
//   i_brd_clk, i_reset_n            clock, asynchronous active-low reset
//   i_req, i_we                     per-port request level and direction
//   i_addr0/1, i_wdata0/1           per-port byte address and write data
//   o_ack, o_rdata, o_busy          completion pulse, read data, controller busy
//   o_sram_cs_n/read_n/write_n      SRAM strobes (all registered)
//   o_sram_addr, o_sram_wdata       SRAM address and write data
//   o_sram_data_oe, i_sram_rdata    tristate enable and pin read data
module sram_arb_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int RD_CYC   = 2,
    parameter int WR_CYC   = 2,
    parameter int TURN_CYC = 1
) (
    input  logic                  i_brd_clk,
    input  logic                  i_reset_n,
    input  logic [1:0]            i_req,
    input  logic [1:0]            i_we,
    input  logic [ADDR_W-1:0]     i_addr0,
    input  logic [ADDR_W-1:0]     i_addr1,
    input  logic [DATA_W-1:0]     i_wdata0,
    input  logic [DATA_W-1:0]     i_wdata1,
    output logic [1:0]            o_ack,
    output logic [DATA_W-1:0]     o_rdata,
    output logic                  o_busy,
    output logic [NUM_CHIPS-1:0]  o_sram_cs_n,
    output logic                  o_sram_read_n,
    output logic                  o_sram_write_n,
    output logic [SRAM_AW-1:0]    o_sram_addr,
    output logic [DATA_W-1:0]     o_sram_wdata,
    output logic                  o_sram_data_oe,
    input  logic [DATA_W-1:0]     i_sram_rdata
);

    localparam logic [3:0] RD_LAST   = 4'(RD_CYC - 1);
    localparam logic [3:0] WR_LAST   = 4'(WR_CYC - 1);
    localparam logic [3:0] TURN_LAST = 4'(TURN_CYC - 1);

    state_e               state_q, state_d;
    logic [3:0]           cnt_q, cnt_d;
    logic                 grant_q, grant_d;
    logic                 we_q, we_d;
    logic [ADDR_W-1:0]    xaddr_q, xaddr_d;
    logic [DATA_W-1:0]    xwdata_q, xwdata_d;

    logic [NUM_CHIPS-1:0] cs_n_q, cs_n_d;
    logic                 read_n_q, read_n_d;
    logic                 write_n_q, write_n_d;
    logic [SRAM_AW-1:0]   sram_addr_q, sram_addr_d;
    logic [DATA_W-1:0]    sram_wdata_q, sram_wdata_d;
    logic                 data_oe_q, data_oe_d;
    logic [1:0]           ack_q, ack_d;
    logic [DATA_W-1:0]    rdata_q, rdata_d;
    logic                 busy_q, busy_d;

    logic                 gnt_valid;
    logic                 gnt_idx;
    logic                 in_xfer;

    sram_rr_arbiter u_arb (
        .clk       (i_brd_clk),
        .rst_n     (i_reset_n),
        .en        (state_q == ST_IDLE),
        .req       (i_req),
        .gnt_valid (gnt_valid),
        .gnt_idx   (gnt_idx)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        grant_d  = grant_q;
        we_d     = we_q;
        xaddr_d  = xaddr_q;
        xwdata_d = xwdata_q;
        rdata_d  = rdata_q;

        unique case (state_q)
            ST_IDLE: begin
                if (gnt_valid) begin
                    grant_d  = gnt_idx;
                    we_d     = i_we[gnt_idx];
                    xaddr_d  = gnt_idx ? i_addr1 : i_addr0;
                    xwdata_d = gnt_idx ? i_wdata1 : i_wdata0;
                    state_d  = ST_SETUP;
                end
            end
            ST_SETUP: begin
                state_d = ST_ACCESS;
                cnt_d   = we_q ? WR_LAST : RD_LAST;
            end
            ST_ACCESS: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_HOLD;
                    if (!we_q) begin
                        rdata_d = i_sram_rdata;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_HOLD: begin
                state_d = (TURN_CYC == 0) ? ST_IDLE : ST_TURN;
                cnt_d   = TURN_LAST;
            end
            ST_TURN: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Pins are registered from the next state so they line up with it;
        // the *_d transfer fields already hold the new grant in IDLE.
        in_xfer      = (state_d == ST_SETUP) || (state_d == ST_ACCESS) || (state_d == ST_HOLD);
        cs_n_d       = in_xfer ? chip_sel_n(xaddr_d[ADDR_W-1:SRAM_AW]) : '1;
        sram_addr_d  = in_xfer ? xaddr_d[SRAM_AW-1:0] : sram_addr_q;
        read_n_d     = !((state_d == ST_ACCESS) && !we_d);
        write_n_d    = !((state_d == ST_ACCESS) && we_d);
        data_oe_d    = in_xfer && we_d;
        sram_wdata_d = (in_xfer && we_d) ? xwdata_d : sram_wdata_q;
        ack_d        = (state_d == ST_HOLD) ? (2'b01 << grant_d) : 2'b00;
        busy_d       = (state_d != ST_IDLE);
    end

    always_ff @(posedge i_brd_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= 4'd0;
            grant_q      <= 1'b0;
            we_q         <= 1'b0;
            xaddr_q      <= '0;
            xwdata_q     <= '0;
            cs_n_q       <= '1;
            read_n_q     <= 1'b1;
            write_n_q    <= 1'b1;
            sram_addr_q  <= '0;
            sram_wdata_q <= '0;
            data_oe_q    <= 1'b0;
            ack_q        <= 2'b00;
            rdata_q      <= '0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            grant_q      <= grant_d;
            we_q         <= we_d;
            xaddr_q      <= xaddr_d;
            xwdata_q     <= xwdata_d;
            cs_n_q       <= cs_n_d;
            read_n_q     <= read_n_d;
            write_n_q    <= write_n_d;
            sram_addr_q  <= sram_addr_d;
            sram_wdata_q <= sram_wdata_d;
            data_oe_q    <= data_oe_d;
            ack_q        <= ack_d;
            rdata_q      <= rdata_d;
            busy_q       <= busy_d;
        end
    end

    assign o_ack          = ack_q;
    assign o_rdata        = rdata_q;
    assign o_busy         = busy_q;
    assign o_sram_cs_n    = cs_n_q;
    assign o_sram_read_n  = read_n_q;
    assign o_sram_write_n = write_n_q;
    assign o_sram_addr    = sram_addr_q;
    assign o_sram_wdata   = sram_wdata_q;
    assign o_sram_data_oe = data_oe_q;

endmodule
